// File: rtl/alu_result_stage.sv
// ALU result/flag stage: holds the architectural Z/C flags and queues register-file writes
// in an in-order FIFO. Define RF_BYPASS_EN to add a read-address bypass match on the queue.
module alu_result_stage #(
   parameter int unsigned DW    = 8,
   parameter int unsigned AW    = 4,
   parameter int unsigned DEPTH = 2
) (
   input  logic                     Clk,
   input  logic                     Reset,
   input  logic                     InValid,
   output logic                     InReady,
   input  logic [DW-1:0]            AluOut,
   input  logic                     AluZero,
   input  logic                     AluCarry,
   input  logic                     WrEn,
   input  logic [AW-1:0]            WrAddr,
   input  logic                     FlagWr,
   output logic                     ZeroIn,
   output logic                     CarryIn,
   output logic                     RfWrEn,
   output logic [AW-1:0]            RfWrAddr,
   output logic [DW-1:0]            RfWrData,
   input  logic                     RfWrAck,
   output logic [$clog2(DEPTH):0]   Count
`ifdef RF_BYPASS_EN
   ,
   input  logic [AW-1:0]            RdAddr,
   output logic                     BypHit,
   output logic [DW-1:0]            BypData
`endif
);

   localparam int unsigned PW = $clog2(DEPTH);
   localparam int unsigned CW = PW + 1;

   logic [AW-1:0] addr_q [DEPTH];
   logic [DW-1:0] data_q [DEPTH];

   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic          z_q, z_d;
   logic          c_q, c_d;

   logic accept;
   logic push;
   logic pop;

   // Full queue blocks accept even when the head is acked this cycle.
   assign InReady = Reset & (count_q < CW'(DEPTH));
   assign accept  = InValid & InReady;
   assign push    = accept & WrEn;
   assign pop     = RfWrEn & RfWrAck;

   assign ZeroIn   = z_q;
   assign CarryIn  = c_q;
   assign RfWrEn   = (count_q != '0);
   assign RfWrAddr = addr_q[rd_ptr_q];
   assign RfWrData = data_q[rd_ptr_q];
   assign Count    = count_q;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      z_d      = z_q;
      c_d      = c_q;

      if (accept && FlagWr) begin
         z_d = AluZero;
         c_d = AluCarry;
      end

      if (push) begin
         wr_ptr_d = wr_ptr_q + 1'b1;
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + 1'b1;
      end

      unique case ({push, pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         z_q      <= 1'b0;
         c_q      <= 1'b0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         z_q      <= z_d;
         c_q      <= c_d;
      end
   end

   // Entry storage needs no reset: occupancy alone decides what is valid.
   always_ff @(posedge Clk) begin
      if (push) begin
         addr_q[wr_ptr_q] <= WrAddr;
         data_q[wr_ptr_q] <= AluOut;
      end
   end

`ifdef RF_BYPASS_EN
   // Walk oldest to youngest so the last match seen is the youngest one.
   always_comb begin
      logic [PW-1:0] idx;
      idx     = '0;
      BypHit  = 1'b0;
      BypData = '0;
      for (int unsigned k = 0; k < DEPTH; k++) begin
         idx = rd_ptr_q + PW'(k);
         if ((CW'(k) < count_q) && (addr_q[idx] == RdAddr)) begin
            BypHit  = 1'b1;
            BypData = data_q[idx];
         end
      end
   end
`endif

endmodule
